// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one 32-bit column per clock, valid/ready on both sides.
// Define INV_MIX_COLUMNS_EN to add InvMixColumns, selected by inv_in at acceptance.
module mix_columns_seq #(
   parameter int NUM_COLS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         inv_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [31:0] fwd_col(input logic [31:0] a);
      logic [7:0]  s [4];
      logic [31:0] r;
      for (int i = 0; i < 4; i++) s[i] = a[31-8*i -: 8];
      r = '0;
      for (int i = 0; i < 4; i++)
         r[31-8*i -: 8] = xt(s[i]) ^ xt(s[(i+1)%4]) ^ s[(i+1)%4] ^ s[(i+2)%4] ^ s[(i+3)%4];
      return r;
   endfunction

`ifdef INV_MIX_COLUMNS_EN
   function automatic logic [31:0] inv_col(input logic [31:0] a);
      logic [7:0]  s [4];
      logic [7:0]  m9 [4];
      logic [7:0]  mb [4];
      logic [7:0]  md [4];
      logic [7:0]  me [4];
      logic [7:0]  x2, x4, x8;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         s[i]  = a[31-8*i -: 8];
         x2    = xt(s[i]);
         x4    = xt(x2);
         x8    = xt(x4);
         m9[i] = x8 ^ s[i];
         mb[i] = x8 ^ x2 ^ s[i];
         md[i] = x8 ^ x4 ^ s[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      r = '0;
      for (int i = 0; i < 4; i++)
         r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
      return r;
   endfunction
`endif

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [127:0]  in_q, in_d;
   logic [127:0]  res_q, res_d;
   logic [31:0]   cur_col, mixed;
   logic          accept;

   assign accept = (state_q == S_IDLE) && in_valid;

   always_comb begin
      cur_col = '0;
      for (int c = 0; c < NUM_COLS; c++)
         if (col_q == CW'(c)) cur_col = in_q[(NUM_COLS-1-c)*32 +: 32];
   end

`ifdef INV_MIX_COLUMNS_EN
   logic inv_q;
   assign mixed = inv_q ? inv_col(cur_col) : fwd_col(cur_col);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         inv_q <= 1'b0;
      else if (accept) inv_q <= inv_in;
   end
`else
   logic unused_inv;
   assign unused_inv = inv_in;
   assign mixed      = fwd_col(cur_col);
`endif

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      in_d    = in_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: if (in_valid) begin
            in_d    = in_data;
            col_d   = '0;
            state_d = S_CALC;
         end
         S_CALC: begin
            for (int c = 0; c < NUM_COLS; c++)
               if (col_q == CW'(c)) res_d[(NUM_COLS-1-c)*32 +: 32] = mixed;
            if (col_q == CW'(NUM_COLS-1)) begin
               col_d   = '0;
               state_d = S_DONE;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         in_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         in_q    <= in_d;
         res_q   <= res_d;
      end
   end

   // in_ready is masked by rst so nothing is offered while reset is held
   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign out_data  = res_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: directed vectors, back-pressure, streaming, mid-op reset.
module tb_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         inv_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   int errs = 0;
   int nchk = 0;
   logic [127:0] sb [$];

   mix_columns_seq #(.NUM_COLS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .inv_in(inv_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nchk++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: generic shift-and-add field multiply over a coefficient row
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p ^= aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
      logic [7:0] co [4];
      logic [7:0] a [4];
      logic [127:0] r = '0;
      logic [7:0] acc;
      if (inv) begin co[0]=8'h0e; co[1]=8'h0b; co[2]=8'h0d; co[3]=8'h09; end
      else     begin co[0]=8'h02; co[1]=8'h03; co[2]=8'h01; co[3]=8'h01; end
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) a[k] = d[127-8*(4*c+k) -: 8];
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc ^= gm(a[(row+k)%4], co[k]);
            r[127-8*(4*c+row) -: 8] = acc;
         end
      end
      return r;
   endfunction

   // Full transaction: offer, accept, measure latency, optional back-pressure, drain.
   task automatic xfer(input logic [127:0] d, input logic inv, input logic [127:0] exp, input int hold);
      int n;
      logic [127:0] e;
      @(negedge clk);
      out_ready = (hold == 0);
      in_data = d; inv_in = inv; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      chk("in_ready_wait", 128'(in_ready), 128'd1);
      sb.push_back(exp);
      @(negedge clk);
      in_valid = 1'b0; in_data = ~d; inv_in = ~inv;
      n = 0;
      while (!out_valid && n < 20) begin
         if (in_ready) chk("in_ready_calc", 128'(in_ready), 128'd0);
         @(negedge clk); n++;
      end
      chk("latency", 128'(n), 128'd4);
      e = sb.pop_front();
      chk("out_data", out_data, e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 128'(out_valid), 128'd1);
         chk("hold_inrdy", 128'(in_ready), 128'd0);
         chk("hold_data", out_data, e);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("drop_valid", 128'(out_valid), 128'd0);
      chk("idle_inrdy", 128'(in_ready), 128'd1);
      chk("keep_data", out_data, e);
   endtask

   initial begin
      logic [127:0] v1, v1e, v2, v2e, iv, ive, d;
      int n;
      v1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      v1e = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      v2  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
      v2e = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
      iv  = v1e;
`ifdef INV_MIX_COLUMNS_EN
      ive = v1;
`else
      ive = model(iv, 1'b0);
`endif

      rst = 1'b1; in_valid = 1'b0; in_data = '0; inv_in = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_inrdy", 128'(in_ready), 128'd0);
      chk("rst_ovalid", 128'(out_valid), 128'd0);
      chk("rst_odata", out_data, 128'd0);
      @(negedge clk); rst = 1'b0;
      #1 chk("post_rst_inrdy", 128'(in_ready), 128'd1);

      xfer(v1, 1'b0, v1e, 0);
      xfer(v2, 1'b0, v2e, 10);
      xfer(iv, 1'b1, ive, 0);

      // Streaming with in_valid held high and data changing every cycle
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            chk("in_ready_done", 128'(in_ready), 128'd0);
            if (sb.size() == 0) chk("stream_unexpected", 128'd1, 128'd0);
            else chk("stream_data", out_data, sb.pop_front());
         end
         if (i < 30) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            in_data = d; in_valid = 1'b1; inv_in = 1'b0;
            if (in_ready) sb.push_back(model(d, 1'b0));
         end else in_valid = 1'b0;
      end
      chk("stream_drained", 128'(sb.size()), 128'd0);
      sb.delete();

      // Reset during the second CALC cycle
      @(negedge clk);
      in_data = v2; inv_in = 1'b0; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_ovalid", 128'(out_valid), 128'd0);
      chk("mid_rst_odata", out_data, 128'd0);
      chk("mid_rst_inrdy", 128'(in_ready), 128'd0);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("mid_rst_rel_inrdy", 128'(in_ready), 128'd1);
      chk("mid_rst_rel_odata", out_data, 128'd0);
      xfer(v1, 1'b0, v1e, 0);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
